// File: rtl/micro_sequencer_pkg.sv
// rtl/micro_sequencer_pkg.sv - shared control types for the micro-sequencer and its decoder
//
// Package `control`: sequencer states, CTRL sub-ops, ALU flag selectors,
// micro-instruction field offsets and the control word that drives the
// ALU, memory, bus and register file. No ports.

package control;

  localparam int OPCODE_W = 5;
  localparam int STEP_W   = 4;
  localparam int ADDR_BUS_WIDTH = OPCODE_W + STEP_W;
  localparam int MICRO_INSTRUCTION_WORD_WIDTH = 14;

  // Micro-instruction field offsets (LSB positions)
  localparam int UI_CTRL_BIT   = 13;
  localparam int UI_SUBOP_LSB  = 11;
  localparam int UI_ALU_LSB    = 9;
  localparam int UI_FLAG_LSB   = 9;
  localparam int UI_MEM_LSB    = 6;
  localparam int UI_LOAD_LSB   = 3;
  localparam int UI_EN_LSB     = 0;
  localparam int UI_TARGET_LSB = 0;

  // Register codes 0..3 select rax..rdx; any code with bit 2 set selects nothing.
  localparam logic [2:0] REG_CODE_NONE = 3'd4;

  typedef enum logic [1:0] {
    USEQ_FETCH = 2'd0,
    USEQ_EXEC  = 2'd1,
    USEQ_HALT  = 2'd2
  } useq_state_e;

  typedef enum logic [1:0] {
    SUBOP_END    = 2'd0,
    SUBOP_BRANCH = 2'd1,
    SUBOP_MODE   = 2'd2,
    SUBOP_SYS    = 2'd3
  } ctrl_subop_e;

  typedef enum logic [1:0] {
    FLAG_NONE      = 2'd0,
    FLAG_ZERO      = 2'd1,
    FLAG_CARRY     = 2'd2,
    FLAG_REMAINDER = 2'd3
  } alu_flag_e;

  typedef enum logic [3:0] {
    ALU_NOP = 4'd0,
    ALU_ADD = 4'd1,
    ALU_SUB = 4'd2,
    ALU_AND = 4'd3,
    ALU_OR  = 4'd4,
    ALU_XOR = 4'd5,
    ALU_NOT = 4'd6,
    ALU_SHL = 4'd7,
    ALU_SHR = 4'd8,
    ALU_INC = 4'd9,
    ALU_DEC = 4'd10,
    ALU_MUL = 4'd11,
    ALU_DIV = 4'd12,
    ALU_CMP = 4'd13
  } alu_op_e;

  typedef enum logic [2:0] {
    MEM_NOP   = 3'd0,
    MEM_READ  = 3'd1,
    MEM_WRITE = 3'd2,
    MEM_FETCH = 3'd3
  } memory_op_e;

  // Bit 1 = load, bit 0 = enable, so both can be asserted together.
  typedef enum logic [1:0] {
    REG_NOP         = 2'b00,
    REG_ENABLE      = 2'b01,
    REG_LOAD        = 2'b10,
    REG_LOAD_ENABLE = 2'b11
  } reg_op_e;

  typedef enum logic {
    BUS_DATA = 1'b0,
    BUS_PC   = 1'b1
  } bus_sel_e;

  // All-zero is the NOP control word.
  typedef struct packed {
    alu_op_e    alu_op;
    logic       alu_enable;
    memory_op_e memory_op;
    reg_op_e    rax_op;
    reg_op_e    rbx_op;
    reg_op_e    rcx_op;
    reg_op_e    rdx_op;
    bus_sel_e   bus_selector;
    logic       data_word_selector;
    logic       control_unit_load;
    logic       next_instr;
    logic       reset;
    logic       halt;
  } control_word_t;

endpackage

// File: rtl/micro_decoder.sv
// rtl/micro_decoder.sv - combinational micro-instruction decoder
//
// Ports:
//   uc_data_i     micro-instruction word from the ROM
//   bus_mode_i    sticky bus selector mode bit
//   dword_mode_i  sticky data word selector mode bit
//   exec_cw_o     control word for an EXEC op (mode bits applied)
//   is_ctrl_o     word is a CTRL op
//   subop_o       CTRL sub-op
//   flag_o        branch condition flag selector
//   target_o      branch target step
//   mode_bus_o    MODE: new bus selector value
//   mode_dword_o  MODE: new data word selector value
//   sys_halt_o    SYS: halt request
//   sys_reset_o   SYS: reset request

module micro_decoder
  import control::*;
(
  input  logic [MICRO_INSTRUCTION_WORD_WIDTH-1:0] uc_data_i,
  input  logic                                    bus_mode_i,
  input  logic                                    dword_mode_i,
  output control_word_t                           exec_cw_o,
  output logic                                    is_ctrl_o,
  output ctrl_subop_e                             subop_o,
  output alu_flag_e                               flag_o,
  output logic [3:0]                              target_o,
  output logic                                    mode_bus_o,
  output logic                                    mode_dword_o,
  output logic                                    sys_halt_o,
  output logic                                    sys_reset_o
);

  logic [2:0] ld_code;
  logic [2:0] en_code;

  assign ld_code = uc_data_i[UI_LOAD_LSB +: 3];
  assign en_code = uc_data_i[UI_EN_LSB +: 3];

  always_comb begin
    exec_cw_o            = '0;
    exec_cw_o.alu_op     = alu_op_e'(uc_data_i[UI_ALU_LSB +: 4]);
    exec_cw_o.alu_enable = (exec_cw_o.alu_op != ALU_NOP);
    exec_cw_o.memory_op  = memory_op_e'(uc_data_i[UI_MEM_LSB +: 3]);
    exec_cw_o.rax_op     = reg_op_e'({ld_code == 3'd0, en_code == 3'd0});
    exec_cw_o.rbx_op     = reg_op_e'({ld_code == 3'd1, en_code == 3'd1});
    exec_cw_o.rcx_op     = reg_op_e'({ld_code == 3'd2, en_code == 3'd2});
    exec_cw_o.rdx_op     = reg_op_e'({ld_code == 3'd3, en_code == 3'd3});
    exec_cw_o.bus_selector       = bus_sel_e'(bus_mode_i);
    exec_cw_o.data_word_selector = dword_mode_i;
  end

  assign is_ctrl_o    = uc_data_i[UI_CTRL_BIT];
  assign subop_o      = ctrl_subop_e'(uc_data_i[UI_SUBOP_LSB +: 2]);
  assign flag_o       = alu_flag_e'(uc_data_i[UI_FLAG_LSB +: 2]);
  assign target_o     = uc_data_i[UI_TARGET_LSB +: 4];
  assign mode_bus_o   = uc_data_i[1];
  assign mode_dword_o = uc_data_i[0];
  assign sys_halt_o   = uc_data_i[1];
  assign sys_reset_o  = uc_data_i[0];

endmodule

// File: rtl/micro_sequencer.sv
// rtl/micro_sequencer.sv - microcoded control unit: FSM, step counter, mode bits, overflow flag
//
// Optional feature macro: SEQ_SINGLE_STEP_EN (adds step_req; EXEC advances only when set).
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   instr_valid/instr_opcode opcode offered by fetch
//   instr_ready              sequencer in FETCH
//   uc_addr                  ROM address {opcode, step}, combinational
//   uc_data                  registered ROM output
//   zero/carry/remainder_flag ALU flags for micro-branches
//   resume                   leave HALT
//   step_req                 (SEQ_SINGLE_STEP_EN only) advance one micro-op
//   cw                       decoded control word
//   step                     current micro-step
//   halted                   in HALT
//   uc_overflow              sticky: a micro-program ran past its last slot

module micro_sequencer #(
  parameter int OPCODE_W = control::OPCODE_W,
  parameter int STEP_W   = control::STEP_W
) (
  input  logic                                             clk,
  input  logic                                             rst,
  input  logic                                             instr_valid,
  input  logic [OPCODE_W-1:0]                              instr_opcode,
  output logic                                             instr_ready,
  output logic [OPCODE_W+STEP_W-1:0]                       uc_addr,
  input  logic [control::MICRO_INSTRUCTION_WORD_WIDTH-1:0] uc_data,
  input  logic                                             zero_flag,
  input  logic                                             carry_flag,
  input  logic                                             remainder_flag,
  input  logic                                             resume,
`ifdef SEQ_SINGLE_STEP_EN
  input  logic                                             step_req,
`endif
  output control::control_word_t                           cw,
  output logic [STEP_W-1:0]                                step,
  output logic                                             halted,
  output logic                                             uc_overflow
);

  import control::*;

  localparam logic [1:0] ST_FETCH = USEQ_FETCH;
  localparam logic [1:0] ST_EXEC  = USEQ_EXEC;
  localparam logic [1:0] ST_HALT  = USEQ_HALT;

  logic [1:0]          state_q, state_d;
  logic [OPCODE_W-1:0] opcode_q, opcode_d;
  logic [STEP_W-1:0]   step_q, step_d;
  logic                bus_mode_q, bus_mode_d;
  logic                dword_mode_q, dword_mode_d;
  logic                ovf_q, ovf_d;

  control_word_t cw_c;
  control_word_t exec_cw;
  logic          is_ctrl;
  ctrl_subop_e   subop;
  alu_flag_e     flag;
  logic [3:0]    target;
  logic          mode_bus, mode_dword, sys_halt, sys_reset;

  logic advance;
  logic taken;
  logic last_step;
  logic seq_step;
  logic end_instr;

  micro_decoder u_decoder (
    .uc_data_i    (uc_data),
    .bus_mode_i   (bus_mode_q),
    .dword_mode_i (dword_mode_q),
    .exec_cw_o    (exec_cw),
    .is_ctrl_o    (is_ctrl),
    .subop_o      (subop),
    .flag_o       (flag),
    .target_o     (target),
    .mode_bus_o   (mode_bus),
    .mode_dword_o (mode_dword),
    .sys_halt_o   (sys_halt),
    .sys_reset_o  (sys_reset)
  );

`ifdef SEQ_SINGLE_STEP_EN
  assign advance = step_req;
`else
  assign advance = 1'b1;
`endif

  always_comb begin
    case (flag)
      FLAG_NONE:      taken = 1'b1;
      FLAG_ZERO:      taken = zero_flag;
      FLAG_CARRY:     taken = carry_flag;
      FLAG_REMAINDER: taken = remainder_flag;
      default:        taken = 1'b0;
    endcase
  end

  assign last_step = (step_q == {STEP_W{1'b1}});

  always_comb begin
    state_d      = state_q;
    opcode_d     = opcode_q;
    step_d       = step_q;
    bus_mode_d   = bus_mode_q;
    dword_mode_d = dword_mode_q;
    ovf_d        = ovf_q;
    cw_c         = '0;
    seq_step     = 1'b0;
    end_instr    = 1'b0;

    unique case (state_q)
      ST_FETCH: begin
        if (instr_valid) begin
          cw_c.control_unit_load = 1'b1;
          opcode_d = instr_opcode;
          step_d   = '0;
          state_d  = ST_EXEC;
        end
      end

      ST_EXEC: begin
        // Without advance the step is held, so uc_addr re-reads the same word.
        if (advance) begin
          if (!is_ctrl) begin
            cw_c     = exec_cw;
            seq_step = 1'b1;
          end else begin
            case (subop)
              SUBOP_END: end_instr = 1'b1;
              SUBOP_BRANCH: begin
                if (taken) step_d = STEP_W'(target);
                else       seq_step = 1'b1;
              end
              SUBOP_MODE: begin
                bus_mode_d   = mode_bus;
                dword_mode_d = mode_dword;
                seq_step     = 1'b1;
              end
              SUBOP_SYS: begin
                if (sys_halt) begin
                  state_d = ST_HALT;
                  step_d  = '0;
                end else if (sys_reset) begin
                  cw_c.reset   = 1'b1;
                  bus_mode_d   = 1'b0;
                  dword_mode_d = 1'b0;
                  state_d      = ST_FETCH;
                  step_d       = '0;
                end else begin
                  seq_step = 1'b1;
                end
              end
              default: end_instr = 1'b1;
            endcase
          end

          // Sequencing past the last slot never wraps: it ends the
          // instruction with the END control word and flags the overflow.
          if (seq_step) begin
            if (last_step) begin
              ovf_d     = 1'b1;
              end_instr = 1'b1;
            end else begin
              step_d = step_q + 1'b1;
            end
          end

          if (end_instr) begin
            cw_c            = '0;
            cw_c.next_instr = 1'b1;
            state_d         = ST_FETCH;
            step_d          = '0;
          end
        end
      end

      ST_HALT: begin
        cw_c.halt = 1'b1;
        if (resume) state_d = ST_FETCH;
      end

      default: state_d = ST_FETCH;
    endcase
  end

  // In EXEC the address is the step being moved to, giving one micro-op per cycle.
  assign uc_addr = (state_q == ST_FETCH) ? {instr_opcode, {STEP_W{1'b0}}}
                                         : {opcode_q, step_d};

  assign cw          = rst ? '0 : cw_c;
  assign instr_ready = (state_q == ST_FETCH);
  assign halted      = (state_q == ST_HALT);
  assign step        = step_q;
  assign uc_overflow = ovf_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_FETCH;
      opcode_q     <= '0;
      step_q       <= '0;
      bus_mode_q   <= 1'b0;
      dword_mode_q <= 1'b0;
      ovf_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      opcode_q     <= opcode_d;
      step_q       <= step_d;
      bus_mode_q   <= bus_mode_d;
      dword_mode_q <= dword_mode_d;
      ovf_q        <= ovf_d;
    end
  end

endmodule

// File: doc/micro_sequencer.md
# micro_sequencer

Microcoded control unit for the 8-bit core. It accepts an opcode from the instruction path and walks that opcode's micro-program in a synchronous microcode ROM, one micro-instruction per cycle. It decodes each 14-bit micro-instruction into a `control::control_word_t`, which drives the ALU, memory, bus and register file, and resolves conditional micro-branches on ALU flags. It sits between instruction fetch and the datapath and is the only source of the control word.

## Interface
Parameters:
- OPCODE_W, 5: opcode width; ROM address is {opcode, step}.
- STEP_W, 4: micro-step counter width; OPCODE_W+STEP_W = `ADDR_BUS_WIDTH (9).

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  reset, synchronous, active-high.
- instr_valid  in  1  opcode offered.
- instr_opcode  in  OPCODE_W  opcode.
- instr_ready  out  1  sequencer can accept an opcode (FETCH state).
- uc_addr  out  9  ROM address, combinational; ROM returns data one cycle later.
- uc_data  in  `MICRO_INSTRUCTION_WORD_WIDTH (14)  registered ROM output.
- zero_flag, carry_flag, remainder_flag  in  1 each  ALU flags, sampled in EXEC.
- resume  in  1  leaves HALT.
- cw  out  control_word_t  decoded control word.
- step  out  STEP_W  current micro-step.
- halted  out  1  state == HALT.
- uc_overflow  out  1  sticky error: step ran past last slot.

## Operation
- States: FETCH, EXEC, HALT. Reset → FETCH, step=0, mode bits=0, uc_overflow=0.
- FETCH:
  - instr_ready=1; uc_addr={instr_opcode,0}.
  - On instr_valid: latch opcode, cw.control_unit_load=1 for that cycle, step<=0, go EXEC.
  - Otherwise cw all-NOP.
- EXEC: decode uc_data (the micro-instruction at {opcode,step}). uc_addr={opcode,next_step}, so throughput is one micro-op per cycle.
- Micro-instruction bit13=0 (EXEC op):
  - [12:9] alu_op; alu_enable = (alu_op != ALU_NOP).
  - [8:6] memory_op.
  - [5:3] load register code; [2:0] enable register code. Codes 0–3 = rax..rdx; 4–7 = none.
  - Selected register gets LOAD / ENABLE. Load and enable of the same register are legal, and both apply.
  - bus_selector and data_word_selector come from sticky mode bits.
  - next_step = step+1.
- Bit13=1 (CTRL op), selected by [12:11]:
  - 00 END: cw.next_instr=1; go FETCH.
  - 01 BRANCH: [10:9] alu_flag_e, [3:0] target.
    - NONE = unconditional.
    - Taken → next_step=target; else step+1.
    - cw otherwise NOP.
  - 10 MODE: [1]→bus_selector, [0]→data_word_selector. New values take effect from the next cycle; cw NOP this cycle.
  - 11 SYS:
    - [1] halt → go HALT.
    - Else [0] reset → cw.reset=1 for one cycle, mode bits cleared, go FETCH.
    - Both set → halt wins.
- Step overflow: an EXEC op at step 2^STEP_W−1 sets uc_overflow, behaves as END (next_instr=1, go FETCH). Never wrap to step 0.
- HALT: cw.halt=1 every cycle, all other cw fields NOP, instr_ready=0. resume → FETCH next cycle.
- rst mid-operation: the in-flight micro-op is abandoned, with no next_instr pulse.

## Timing
- cw is combinational from state, mode and uc_data, and is forced all-zero while rst is high.
- Accept at cycle N → step 0 control word in N+1; an n-step micro-program occupies cycles N+1..N+n, and END is in the last of these.
- FETCH re-entered the cycle after END, so the next opcode is accepted one cycle after END at the earliest.
- Flags are combinational into the branch decision in the same cycle. The flag must be stable before the BRANCH cycle, i.e. produced by an earlier step.
- After rst deasserts: FETCH, instr_ready=1, cw zero, uc_addr={instr_opcode,0}.

## Configuration
- SEQ_SINGLE_STEP_EN defined: adds input step_req. In EXEC the current micro-op is emitted only in a cycle with step_req=1.
  - Otherwise: cw all-NOP, step and uc_addr held (the ROM re-reads the same word), no state change.
  - FETCH and HALT are unaffected.
- Undefined: no step_req port; EXEC advances every cycle.

## Structure
- Shared package `control`: useq_state_e, ctrl_subop_e (END, BRANCH, MODE, SYS), REG_CODE_NONE=4, OPCODE_W/STEP_W constants, micro-instruction field offsets.
- Sub-module micro_decoder: combinational uc_data + mode bits → cw fields and CTRL info (is_ctrl, subop, flag, target). micro_sequencer holds the FSM, step counter, mode bits and overflow flag.

## Test plan
- Reset, then opcode 3 valid in cycle 1 → cycle 1 control_unit_load=1, uc_addr=0x030; cycle 2 uc_addr=0x031.
- Program at opcode 3: {ADD, load rax, enable rbx}, END → cycle 2 cw.alu_op=ADD, alu_enable=1, rax_op=LOAD, rbx_op=ENABLE; cycle 3 next_instr=1; cycle 4 instr_ready=1.
- BRANCH ZERO→step 5 at step 1: zero_flag=1 → uc_addr={op,5}; zero_flag=0 → {op,2}.
- MODE 0b11 then EXEC op → next cycle cw.bus_selector=PC, data_word_selector=1; SYS reset → cw.reset=1 and mode cleared.
- 16 EXEC ops with no END → uc_overflow=1, next_instr=1 at step 15, FETCH next.
- SYS halt → halted=1, cw.halt=1 held; resume → FETCH; rst during EXEC → FETCH with no next_instr.
